// File: rtl/csr_if.sv
// Bus between the CSR decode / EX stage and the machine-mode CSR file.
// Carries decoded strobes, operands, interrupt lines and redirect/stall results.
interface csr_if;
    logic        csr_en_sig;
    logic        csr_read;
    logic        csr_write;
    logic        csr_MRET;
    logic        csr_WFI;
    logic        csr_imm_mode;
    logic [2:0]  csr_WSC_mode;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] ex_pc;
    logic        int_ok;
    logic        ext_irq;
    logic        tmr_irq;
    logic        instr_retire;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_redirect;
    logic [31:0] csr_target;
    logic        csr_stall;

    modport master (
        output csr_en_sig, csr_read, csr_write,
        output csr_MRET, csr_WFI, csr_imm_mode,
        output csr_WSC_mode, csr_addr, rs1_data,
        output zimm, ex_pc, int_ok,
        output ext_irq, tmr_irq, instr_retire,
        input  csr_rdata, csr_illegal,
        input  csr_redirect, csr_target, csr_stall
    );

    modport slave (
        input  csr_en_sig, csr_read, csr_write,
        input  csr_MRET, csr_WFI, csr_imm_mode,
        input  csr_WSC_mode, csr_addr, rs1_data,
        input  zimm, ex_pc, int_ok,
        input  ext_irq, tmr_irq, instr_retire,
        output csr_rdata, csr_illegal,
        output csr_redirect, csr_target, csr_stall
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap entry, MRET, WFI sleep and
// 64-bit cycle/instret counters; drives PC redirect and stall.
module csr_file #(
    parameter logic [31:0] MTVEC_VAL = 32'h0000_0100,
    parameter int          REGWIDTH  = 32
) (
    input logic  clk,
    input logic  rst_n,
    csr_if.slave bus
);
    typedef enum logic {RUN, SLEEP} state_e;

    state_e state_q, state_d;
    logic mie_q, mie_d, mpie_q, mpie_d;
    logic mtie_q, mtie_d, meie_q, meie_d;
    logic [REGWIDTH-1:0] mepc_q, mepc_d;
    logic [REGWIDTH-1:0] wfi_pc_q, wfi_pc_d;
    logic [REGWIDTH-1:0] target_q, target_d;
    logic redirect_q, redirect_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [REGWIDTH-1:0] old_val, src, wdata;
    logic mapped, ro, illegal, wr_mode, do_write, pend;

    // Address decode: pre-write value plus mapped/read-only flags
    always_comb begin
        old_val = '0;
        mapped  = 1'b1;
        ro      = 1'b0;
        case (bus.csr_addr)
            12'h300: old_val = {19'b0, 2'b11, 3'b0, mpie_q,
                                3'b0, mie_q, 3'b0};
            12'h304: old_val = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
            12'h305: begin old_val = MTVEC_VAL; ro = 1'b1; end
            12'h341: old_val = mepc_q;
            12'h344: begin
                old_val = {20'b0, bus.ext_irq, 3'b0,
                           bus.tmr_irq, 7'b0};
                ro = 1'b1;
            end
            12'hB00: old_val = mcycle_q[31:0];
            12'hB80: old_val = mcycle_q[63:32];
            12'hB02: old_val = minstret_q[31:0];
            12'hB82: old_val = minstret_q[63:32];
            12'hC00: begin old_val = mcycle_q[31:0];    ro = 1'b1; end
            12'hC80: begin old_val = mcycle_q[63:32];   ro = 1'b1; end
            12'hC02: begin old_val = minstret_q[31:0];  ro = 1'b1; end
            12'hC82: begin old_val = minstret_q[63:32]; ro = 1'b1; end
            default: mapped = 1'b0;
        endcase
    end

    always_comb begin
        src   = bus.csr_imm_mode ? {27'b0, bus.zimm} : bus.rs1_data;
        wdata = old_val;
        case (bus.csr_WSC_mode)
            3'd1:    wdata = src;
            3'd2:    wdata = old_val | src;
            3'd3:    wdata = old_val & ~src;
            default: wdata = old_val;
        endcase
    end

    assign wr_mode = (bus.csr_WSC_mode == 3'd1) |
                     (bus.csr_WSC_mode == 3'd2) |
                     (bus.csr_WSC_mode == 3'd3);
    assign illegal = bus.csr_en_sig & bus.csr_read &
                     ~bus.csr_MRET & ~bus.csr_WFI &
                     (~mapped | (bus.csr_write & ro));
    assign do_write = bus.csr_en_sig & bus.csr_write & wr_mode &
                      ~illegal & mapped & ~ro & (state_q == RUN);
    assign pend = (mtie_q & bus.tmr_irq) | (meie_q & bus.ext_irq);

    assign bus.csr_rdata    = (bus.csr_en_sig & bus.csr_read) ?
                              old_val : '0;
    assign bus.csr_illegal  = illegal;
    assign bus.csr_redirect = redirect_q;
    assign bus.csr_target   = target_q;
    assign bus.csr_stall    = (state_q == SLEEP);

    always_comb begin
        state_d    = state_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtie_d     = mtie_q;
        meie_d     = meie_q;
        mepc_d     = mepc_q;
        wfi_pc_d   = wfi_pc_q;
        target_d   = target_q;
        redirect_d = 1'b0;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'b0, bus.instr_retire};
        if (do_write) begin
            case (bus.csr_addr)
                12'h300: begin mie_d = wdata[3]; mpie_d = wdata[7]; end
                12'h304: begin mtie_d = wdata[7]; meie_d = wdata[11]; end
                12'h341: mepc_d = {wdata[31:2], 2'b00};
                12'hB00: mcycle_d = {mcycle_q[63:32], wdata};
                12'hB80: mcycle_d = {wdata, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wdata};
                12'hB82: minstret_d = {wdata, minstret_q[31:0]};
                default: ;
            endcase
        end
        unique case (state_q)
            RUN: begin
                if (bus.csr_WFI) begin
                    state_d  = SLEEP;
                    wfi_pc_d = bus.ex_pc + 32'd4;
                end else if (bus.csr_MRET) begin
                    mie_d      = mpie_q;
                    mpie_d     = 1'b1;
                    redirect_d = 1'b1;
                    target_d   = mepc_q;
                end else if (pend & mie_q & bus.int_ok &
                             ~bus.csr_en_sig) begin
                    mepc_d     = bus.ex_pc;
                    mpie_d     = mie_q;
                    mie_d      = 1'b0;
                    redirect_d = 1'b1;
                    target_d   = MTVEC_VAL;
                end
            end
            SLEEP: begin
                // Wake on any enabled pending source; trap only if MIE set
                if (pend) begin
                    state_d = RUN;
                    if (mie_q) begin
                        mepc_d     = wfi_pc_q;
                        mpie_d     = 1'b1;
                        mie_d      = 1'b0;
                        redirect_d = 1'b1;
                        target_d   = MTVEC_VAL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mepc_q     <= '0;
            wfi_pc_q   <= '0;
            target_q   <= '0;
            redirect_q <= 1'b0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtie_q     <= mtie_d;
            meie_q     <= meie_d;
            mepc_q     <= mepc_d;
            wfi_pc_q   <= wfi_pc_d;
            target_q   <= target_d;
            redirect_q <= redirect_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
endmodule
